// File: rtl/div_pkg.sv
// Shared definitions for the iterative RV32M divider: widths, op encoding, FSM states.
package div_pkg;

  localparam int unsigned DIV_XLEN = 32;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  localparam logic [DIV_XLEN-1:0] DIV_ZERO_Q = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_if.sv
// Request/response bundle between the control unit and the divider.
interface div_if #(parameter int unsigned XLEN = div_pkg::DIV_XLEN);

  logic            start_i;
  logic [1:0]      op_i;
  logic [XLEN-1:0] a_i;
  logic [XLEN-1:0] b_i;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output start_i, op_i, a_i, b_i,
    input  busy_o, done_o, result_o
  );

  modport slave (
    input  start_i, op_i, a_i, b_i,
    output busy_o, done_o, result_o
  );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left and try subtracting the divisor.
module div_step import div_pkg::*; #(
  parameter int unsigned XLEN = DIV_XLEN
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] dvs_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN-1:0] dvs_inv;
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   diff;
  logic            carry;
  logic            unused_diff_msb;

  not_gate #(.WIDTH(XLEN)) u_dvs_inv (
    .a_i (dvs_i),
    .y_o (dvs_inv)
  );

  assign rem_sh = {rem_i, quo_i[XLEN-1]};

  // Carry out of rem_sh + ~{0,dvs} + 1 is set exactly when rem_sh >= dvs (no borrow).
  assign {carry, diff} = {1'b0, rem_sh} + {1'b0, 1'b1, dvs_inv} + (XLEN+2)'(1);

  // On success the difference is below the divisor, so its top bit is always zero.
  assign unused_diff_msb = diff[XLEN];

  assign rem_o = carry ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
  assign quo_o = {quo_i[XLEN-2:0], carry};

endmodule

// File: rtl/not_gate.sv
// Configurable bitwise inverter, shared across the datapath.
module not_gate #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  output logic [WIDTH-1:0] y_o
);

  assign y_o = ~a_i;

endmodule

// File: rtl/div_unit.sv
// Iterative 32-bit divider for DIV/DIVU/REM/REMU: magnitude load, XLEN restoring steps, sign fix.
module div_unit import div_pkg::*; #(
  parameter int unsigned XLEN = DIV_XLEN
) (
  input  logic  clk_i,
  input  logic  rst_i,
  div_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(XLEN);

  div_state_t      state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0] quo, rem, dvs, a_lat, result_q;
  logic [1:0]      op_q;
  logic            sign_a, sign_b, div0;
  logic            busy_q, done_q;
  logic            busy_d, done_d;

  logic            signed_op;
  logic [XLEN-1:0] a_inv, b_inv, quo_inv, rem_inv;
  logic [XLEN-1:0] a_mag, b_mag, quo_fix, rem_fix, res_fix;
  logic [XLEN-1:0] rem_step, quo_step;

  assign signed_op = ~bus.op_i[0];

  not_gate #(.WIDTH(XLEN)) u_a_inv   (.a_i(bus.a_i), .y_o(a_inv));
  not_gate #(.WIDTH(XLEN)) u_b_inv   (.a_i(bus.b_i), .y_o(b_inv));
  not_gate #(.WIDTH(XLEN)) u_quo_inv (.a_i(quo),     .y_o(quo_inv));
  not_gate #(.WIDTH(XLEN)) u_rem_inv (.a_i(rem),     .y_o(rem_inv));

  assign a_mag = (signed_op && bus.a_i[XLEN-1]) ? a_inv + XLEN'(1) : bus.a_i;
  assign b_mag = (signed_op && bus.b_i[XLEN-1]) ? b_inv + XLEN'(1) : bus.b_i;

  assign quo_fix = (sign_a ^ sign_b) ? quo_inv + XLEN'(1) : quo;
  assign rem_fix = sign_a ? rem_inv + XLEN'(1) : rem;

  // op_q[1] selects the remainder flavours; divide-by-zero returns the original dividend there.
  assign res_fix = div0 ? (op_q[1] ? a_lat : XLEN'(DIV_ZERO_Q))
                        : (op_q[1] ? rem_fix : quo_fix);

  div_step #(.XLEN(XLEN)) u_step (
    .rem_i (rem),
    .quo_i (quo),
    .dvs_i (dvs),
    .rem_o (rem_step),
    .quo_o (quo_step)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    done_d   = 1'b0;
    case (state)
      IDLE: if (bus.start_i) state_nx = (bus.b_i == '0) ? FIX : CALC;
      CALC: if (cnt == '0) state_nx = FIX;
      FIX: begin
        state_nx = IDLE;
        done_d   = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
    busy_d = (state_nx != IDLE);
  end

  // Operand capture, iteration and result registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt      <= '0;
      quo      <= '0;
      rem      <= '0;
      dvs      <= '0;
      a_lat    <= '0;
      op_q     <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      div0     <= 1'b0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      case (state)
        IDLE: if (bus.start_i) begin
          op_q   <= bus.op_i;
          sign_a <= signed_op & bus.a_i[XLEN-1];
          sign_b <= signed_op & bus.b_i[XLEN-1];
          quo    <= a_mag;
          rem    <= '0;
          dvs    <= b_mag;
          a_lat  <= bus.a_i;
          cnt    <= CNT_W'(XLEN - 1);
          div0   <= (bus.b_i == '0);
        end
        CALC: begin
          rem <= rem_step;
          quo <= quo_step;
          cnt <= cnt - CNT_W'(1);
        end
        FIX:     result_q <= res_fix;
        default: ;
      endcase
    end
  end

  assign bus.busy_o   = busy_q;
  assign bus.done_o   = done_q;
  assign bus.result_o = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expected results queued at issue, checked on done_o.
module tb_div_unit;
  import div_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  div_if bus ();

  div_unit u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [31:0] exp_q[$];
  int          lat_q[$];
  int          t0_q[$];
  string       tag_q[$];
  string       mon_tag;
  logic        done_prev = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    case (op)
      DIV_OP_DIV:  return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'($signed(a) / $signed(b));
      DIV_OP_DIVU: return a / b;
      DIV_OP_REM:  return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'($signed(a) % $signed(b));
      default:     return a % b;
    endcase
  endfunction

  // Monitor: pops the scoreboard on each done_o and checks result and latency.
  always @(negedge clk) begin
    if (!rst) begin
      if (done_prev) check("done_pulse", 32'(bus.done_o), 32'd0);
      if (bus.done_o) begin
        check("busy_done_excl", 32'(bus.busy_o), 32'd0);
        if (exp_q.size() == 0) begin
          check("spurious_done", 32'd1, 32'd0);
        end else begin
          mon_tag = tag_q.pop_front();
          check({mon_tag, "_res"}, bus.result_o, exp_q.pop_front());
          check({mon_tag, "_lat"}, 32'(cyc - t0_q.pop_front()), 32'(lat_q.pop_front()));
        end
      end
    end
    done_prev = bus.done_o;
  end

  // Waits for the divider to be idle (possibly the done cycle), then issues one request.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input string tag, input bit in_done_cycle);
    int n = 0;
    @(negedge clk);
    while (bus.busy_o === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check({tag, "_idle_timeout"}, 32'd1, 32'd0);
    if (in_done_cycle) check({tag, "_in_done_cycle"}, 32'(bus.done_o), 32'd1);
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.a_i     = a;
    bus.b_i     = b;
    exp_q.push_back(exp);
    lat_q.push_back((b == 32'd0) ? 1 : 33);
    t0_q.push_back(cyc + 1);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    bus.op_i    = 2'($urandom);
    bus.a_i     = $urandom;
    bus.b_i     = $urandom;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check({tag, "_drain_timeout"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    bus.start_i = 1'b0;
    bus.op_i    = 2'b00;
    bus.a_i     = '0;
    bus.b_i     = '0;
    #12;
    check("rst_busy",   32'(bus.busy_o), 32'd0);
    check("rst_done",   32'(bus.done_o), 32'd0);
    check("rst_result", bus.result_o,    32'd0);
    @(negedge clk);
    rst = 1'b0;

    issue(DIV_OP_DIVU, 32'd100,       32'd7,         32'h0000_000E, "divu_100_7",   1'b0);
    issue(DIV_OP_REMU, 32'd100,       32'd7,         32'h0000_0002, "remu_100_7",   1'b1);
    issue(DIV_OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, "div_m7_2",     1'b1);
    issue(DIV_OP_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, "rem_m7_2",     1'b1);
    issue(DIV_OP_DIV,  32'd5,         32'd0,         32'hFFFF_FFFF, "div_5_0",      1'b1);
    issue(DIV_OP_REMU, 32'd5,         32'd0,         32'h0000_0005, "remu_5_0",     1'b1);
    issue(DIV_OP_DIV,  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, "div_m7_0",     1'b1);
    issue(DIV_OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf",      1'b1);
    issue(DIV_OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "rem_ovf",      1'b1);
    issue(DIV_OP_DIVU, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, "divu_max_1",   1'b1);
    drain("directed");

    // A start pulse mid-operation must not disturb the in-flight divide.
    issue(DIV_OP_DIVU, 32'd100, 32'd7, 32'h0000_000E, "ignore_start", 1'b0);
    repeat (8) @(negedge clk);
    bus.start_i = 1'b1;
    bus.op_i    = DIV_OP_DIVU;
    bus.a_i     = 32'd1;
    bus.b_i     = 32'd1;
    @(negedge clk);
    bus.start_i = 1'b0;
    issue(DIV_OP_REMU, 32'd9, 32'd4, 32'h0000_0001, "b2b_remu_9_4", 1'b1);
    drain("b2b");

    // Asynchronous reset mid-operation discards the divide and clears outputs at once.
    issue(DIV_OP_DIVU, 32'd100, 32'd7, 32'h0000_000E, "rst_abort", 1'b0);
    repeat (14) @(posedge clk);
    #3;
    exp_q.delete();
    lat_q.delete();
    t0_q.delete();
    tag_q.delete();
    check("midop_busy_before_rst", 32'(bus.busy_o), 32'd1);
    rst = 1'b1;
    #1;
    check("midop_rst_busy",   32'(bus.busy_o), 32'd0);
    check("midop_rst_done",   32'(bus.done_o), 32'd0);
    check("midop_rst_result", bus.result_o,    32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("post_rst_busy",   32'(bus.busy_o), 32'd0);
    check("post_rst_result", bus.result_o,    32'd0);

    for (int i = 0; i < 12; i++) begin
      rop = 2'($urandom);
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 20));
        2:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
        default: rb = $urandom;
      endcase
      if (i == 0) begin
        rop = DIV_OP_REM;
        ra  = 32'h8000_0000;
        rb  = 32'hFFFF_FFFF;
      end
      issue(rop, ra, rb, ref_res(rop, ra, rb), $sformatf("rand%0d", i), 1'b0);
    end
    drain("random");
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
